// File: rtl/light_stalk_ctrl_if.sv
// Stalk-side signal bundle for light_stalk_ctrl.
// The driver side (master) supplies ignition and the raw buttons and
// observes the registered lamp levels. The controller side (slave) does
// the reverse.
interface light_stalk_ctrl_if;
  logic ignition;   // synchronous to clk
  logic btn_light;  // raw, asynchronous, active-high
  logic btn_beam;   // raw, asynchronous, active-high
  logic btn_flash;  // raw, asynchronous, active-high
  logic turn_li;    // 1 when headlights on (LOW or HIGH)
  logic turn_hili;  // 1 when high beam selected
  logic fast_hili;  // active-low passing-flash request

  modport master (
    output ignition, btn_light, btn_beam, btn_flash,
    input  turn_li, turn_hili, fast_hili
  );

  modport slave (
    input  ignition, btn_light, btn_beam, btn_flash,
    output turn_li, turn_hili, fast_hili
  );
endinterface

// File: rtl/light_stalk_ctrl.sv
// Light stalk controller: synchronizes and debounces the three stalk
// buttons, runs the OFF/LOW/HIGH headlight FSM and generates the
// active-low passing-flash request with a minimum low time.
//
// Optional feature: define LIGHT_STALK_AUTO_OFF_EN for "follow-me-home".
// When defined, a falling ignition holds the current state for
// AUTO_OFF_CYCLES cycles before forcing OFF; when undefined, ignition low
// forces OFF on the next edge and no hold counter exists.
module light_stalk_ctrl #(
  parameter int DEB_CYCLES      = 16,  // stable cycles before a level flips (>=1)
  parameter int FLASH_MIN       = 8,   // minimum fast_hili low time (>=1)
  parameter int AUTO_OFF_CYCLES = 64   // follow-me-home hold time
) (
  input  logic              clk,
  input  logic              rst_n,
  light_stalk_ctrl_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int FW = $clog2(FLASH_MIN + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_SAT = FW'(FLASH_MIN);

  // Bit positions of the buttons inside the packed button vectors.
  localparam int BTN_LIGHT = 0;
  localparam int BTN_BEAM  = 1;
  localparam int BTN_FLASH = 2;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  logic [2:0] btn_raw;
  logic [2:0] press;        // one-cycle rising-edge pulses of debounced levels
  logic       flash_level;  // debounced flash button level

  assign btn_raw = {bus.btn_flash, bus.btn_beam, bus.btn_light};

  // ------------------------------------------------------------------
  // Per-button synchronizer, debouncer and press detector
  // ------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      logic          sync1_reg;
      logic          sync2_reg;
      logic          level_reg;
      logic          prev_reg;
      logic [DW-1:0] cnt_reg;

      // Two-flop synchronizer for the asynchronous raw button.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn_raw[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Debounce: the level flips only after DEB_CYCLES consecutive
      // synchronized samples disagree with it; any agreeing sample
      // restarts the count, so short glitches are discarded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
          prev_reg  <= 1'b0;
        end else begin
          prev_reg <= level_reg;
          if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            level_reg <= ~level_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + DW'(1);
          end
        end
      end

      // A press is the single cycle where the debounced level has just risen.
      assign press[gi] = level_reg & ~prev_reg;

      if (gi == BTN_FLASH) begin : g_flash_level
        assign flash_level = level_reg;
      end
    end
  endgenerate

  // ------------------------------------------------------------------
  // Headlight FSM
  // ------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;
  state_t press_state;  // state after applying the press rules only
  logic   turn_li_reg;
  logic   turn_hili_reg;

  // Press rules: light toggles on/off and beats a simultaneous beam press;
  // beam toggles LOW/HIGH and does nothing while OFF.
  always_comb begin
    press_state = state_reg;
    if (press[BTN_LIGHT]) begin
      press_state = (state_reg == ST_OFF) ? ST_LOW : ST_OFF;
    end else if (press[BTN_BEAM]) begin
      case (state_reg)
        ST_LOW:  press_state = ST_HIGH;
        ST_HIGH: press_state = ST_LOW;
        default: press_state = state_reg;
      endcase
    end
  end

`ifdef LIGHT_STALK_AUTO_OFF_EN
  localparam int AW = $clog2(AUTO_OFF_CYCLES + 1);
  localparam logic [AW-1:0] AOFF_SAT = AW'(AUTO_OFF_CYCLES);

  logic [AW-1:0] aoff_cnt_reg;
  logic [AW-1:0] aoff_cnt_next;

  // Next state: with ignition low the state is held while the hold counter
  // runs, then forced OFF; the counter saturates so OFF stays put.
  always_comb begin
    state_next    = state_reg;
    aoff_cnt_next = aoff_cnt_reg;
    if (!bus.ignition) begin
      if (aoff_cnt_reg == AOFF_SAT) begin
        state_next = ST_OFF;
      end else begin
        aoff_cnt_next = aoff_cnt_reg + AW'(1);
      end
    end else begin
      aoff_cnt_next = '0;
      state_next    = press_state;
    end
  end

  // Follow-me-home hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aoff_cnt_reg <= '0;
    end else begin
      aoff_cnt_reg <= aoff_cnt_next;
    end
  end
`else
  // Next state: ignition low forces OFF and masks all presses.
  always_comb begin
    state_next = state_reg;
    if (!bus.ignition) begin
      state_next = ST_OFF;
    end else begin
      state_next = press_state;
    end
  end
`endif

  // State register plus registered decodes of the next state, so the
  // lamp outputs change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_OFF;
      turn_li_reg   <= 1'b0;
      turn_hili_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      turn_li_reg   <= (state_next != ST_OFF);
      turn_hili_reg <= (state_next == ST_HIGH);
    end
  end

  // ------------------------------------------------------------------
  // Passing flash
  // ------------------------------------------------------------------
  logic          fast_reg;
  logic          fast_next;
  logic [FW-1:0] flash_cnt_reg;   // cycles spent low, saturating at FLASH_MIN
  logic [FW-1:0] flash_cnt_next;

  // Flash next state: a press while high pulls low and starts the window;
  // while low, stay low until the window has elapsed and the debounced
  // button is released. Presses while low never restart the window.
  always_comb begin
    fast_next      = fast_reg;
    flash_cnt_next = flash_cnt_reg;
    if (fast_reg) begin
      if (press[BTN_FLASH]) begin
        fast_next      = 1'b0;
        flash_cnt_next = FW'(1);
      end
    end else if (flash_cnt_reg < FLASH_SAT) begin
      flash_cnt_next = flash_cnt_reg + FW'(1);
    end else if (!flash_level) begin
      fast_next      = 1'b1;
      flash_cnt_next = '0;
    end
  end

  // Flash output register and window counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_reg      <= 1'b1;
      flash_cnt_reg <= '0;
    end else begin
      fast_reg      <= fast_next;
      flash_cnt_reg <= flash_cnt_next;
    end
  end

  assign bus.turn_li   = turn_li_reg;
  assign bus.turn_hili = turn_hili_reg;
  assign bus.fast_hili = fast_reg;

endmodule
